// File: rtl/aes128_dec.sv
// AES-128 iterative decryptor: on-the-fly forward key expansion to rk10, then ten
// inverse rounds, rolling the key schedule backwards one round key per cycle.
package aes128_dec_pkg;
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 by repeated squaring; maps 0 to 0 as the S-box construction requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int i = 1; i < 8; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      logic [7:0] r;
      case (n)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction
endpackage

module aes_sbox
   import aes128_dec_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] inv;
   always_comb begin
      inv = gf_inv(a);
      y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module aes_inv_sbox
   import aes128_dec_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] t;
   always_comb begin
      t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      y = gf_inv(t);
   end
endmodule

module aes128_dec
   import aes128_dec_pkg::*;
(
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] ct,
   output logic         busy,
   output logic         done,
   output logic [127:0] pt
);
   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [127:0]   key_q, key_d;
   logic [127:0]   blk_q, blk_d;
   logic [127:0]   pt_q, pt_d;
   logic           done_q, done_d;

   logic [31:0]    w0, w1, w2, w3, sub_in, rot, sub_out, rc;
   logic [31:0]    f0, f1, f2, f3, p0, p1, p2, p3;
   logic [127:0]   key_fwd, key_inv, isr, isb, ark, imc, round_out;

   assign {w0, w1, w2, w3} = key_q;
   // Rolling backwards, the previous w3 is w3'^w2'; the SubWord lanes are shared.
   assign sub_in = (state_q == ROUND) ? (w3 ^ w2) : w3;
   assign rot    = {sub_in[23:0], sub_in[31:24]};
   assign rc     = {rcon(cnt_q), 24'h0};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_subword
         aes_sbox u_sbox (.a(rot[31-8*gi -: 8]), .y(sub_out[31-8*gi -: 8]));
      end
   endgenerate

   assign f0 = w0 ^ sub_out ^ rc;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
   assign key_fwd = {f0, f1, f2, f3};

   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;
   assign p0 = w0 ^ sub_out ^ rc;
   assign key_inv = {p0, p1, p2, p3};

   // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         localparam int row = gi % 4;
         localparam int col = gi / 4;
         localparam int src = row + 4 * ((col - row + 4) % 4);
         assign isr[127-8*gi -: 8] = blk_q[127-8*src -: 8];
         aes_inv_sbox u_isbox (.a(isr[127-8*gi -: 8]), .y(isb[127-8*gi -: 8]));
      end
      for (gi = 0; gi < 4; gi++) begin : g_col
         assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
      end
   endgenerate

   assign ark       = isb ^ key_inv;
   assign round_out = (cnt_q == 4'd1) ? ark : imc;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      blk_d   = blk_q;
      pt_d    = pt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key;
               blk_d   = ct;
               cnt_d   = 4'd1;
               state_d = KEYEXP;
            end
         end
         KEYEXP: begin
            key_d = key_fwd;
            if (cnt_q == 4'd10) begin
               blk_d   = blk_q ^ key_fwd;
               state_d = ROUND;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ROUND: begin
            key_d = key_inv;
            blk_d = round_out;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               pt_d    = round_out;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         key_q   <= '0;
         blk_q   <= '0;
         pt_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         blk_q   <= blk_d;
         pt_q    <= pt_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign pt   = pt_q;
endmodule
